// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2c_pkg
// Purpose  : Shared FSM state encoding and register map for the I2C target.
// Revision : 1.0  initial release
// ============================================================================
package i2c_pkg;

    typedef enum logic [7:0] {
        ST_IDLE      = 8'd0,
        ST_ADDR      = 8'd1,
        ST_ADDR_ACK  = 8'd2,
        ST_PTR       = 8'd3,
        ST_PTR_ACK   = 8'd4,
        ST_WR_DATA   = 8'd5,
        ST_WR_ACK    = 8'd6,
        ST_RD_DATA   = 8'd7,
        ST_RD_ACK    = 8'd8,
        ST_WAIT_STOP = 8'd9
    } i2c_state_t;

    localparam logic [7:0] REG_TEMP_MSB = 8'h00;
    localparam logic [7:0] REG_TEMP_LSB = 8'h01;
    localparam logic [7:0] REG_STATUS   = 8'h02;
    localparam logic [7:0] REG_CONFIG   = 8'h03;
    localparam logic [7:0] REG_ID       = 8'h0B;

    function automatic logic is_ack_state(input i2c_state_t s);
        return (s == ST_ADDR_ACK) || (s == ST_PTR_ACK) || (s == ST_WR_ACK);
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_bus_sync.sv
`default_nettype none
// ============================================================================
// Module   : i2c_bus_sync
// Purpose  : Synchronizes SCL/SDA, flags SCL edges and START/STOP conditions.
// Revision : 1.0  initial release
// ============================================================================
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_q;
    logic                   r_sda_q;
    logic                   w_scl;
    logic                   w_sda;

    // All flops come out of reset at 1 so an idle bus produces no edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_q    <= 1'b1;
            r_sda_q    <= 1'b1;
        end else begin
            r_scl_sync[0] <= i_scl;
            r_sda_sync[0] <= i_sda;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_scl_sync[i] <= r_scl_sync[i-1];
                r_sda_sync[i] <= r_sda_sync[i-1];
            end
            r_scl_q <= w_scl;
            r_sda_q <= w_sda;
        end
    end

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign o_sda      = w_sda;
    assign o_scl_rise = w_scl & ~r_scl_q;
    assign o_scl_fall = ~w_scl & r_scl_q;
    assign o_start    = w_scl & r_scl_q & r_sda_q & ~w_sda;
    assign o_stop     = w_scl & r_scl_q & ~r_sda_q & w_sda;

endmodule
`default_nettype wire

// File: rtl/i2c_target_responder.sv
`default_nettype none
// ============================================================================
// Module   : i2c_target_responder
// Purpose  : I2C target with a small temperature-sensor style register file.
// Revision : 1.0  initial release
// ============================================================================
module i2c_target_responder
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = 7'h48,
    parameter logic [7:0] DEVICE_ID   = 8'hCB,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [15:0] temp_in,
    output logic [7:0]  config_out,
    output logic        busy,
    output logic [7:0]  state_dbg,
    output logic        ack_dbg
);

    logic w_sda;
    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;

    i2c_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_bus_sync (
        .clk        (clk),
        .reset      (reset),
        .i_scl      (scl_in),
        .i_sda      (sda_in),
        .o_sda      (w_sda),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    i2c_state_t  r_state,    w_state_nxt;
    logic [3:0]  r_bit_cnt,  w_bit_cnt_nxt;
    logic [7:0]  r_shift,    w_shift_nxt;
    logic [7:0]  r_tx,       w_tx_nxt;
    logic [7:0]  r_ptr,      w_ptr_nxt;
    logic [7:0]  r_config,   w_config_nxt;
    logic [15:0] r_snap,     w_snap_nxt;
    logic        r_sda_oe,   w_sda_oe_nxt;
    logic        r_busy,     w_busy_nxt;
    logic        r_nack,     w_nack_nxt;
    logic [7:0]  w_byte;
    logic [7:0]  w_rd_byte;

    // Byte as it will look once the bit on this SCL rise is shifted in.
    assign w_byte = {r_shift[6:0], w_sda};

    always_comb begin
        case (r_ptr)
            REG_TEMP_MSB: w_rd_byte = r_snap[15:8];
            REG_TEMP_LSB: w_rd_byte = r_snap[7:0];
            REG_STATUS:   w_rd_byte = 8'h00;
            REG_CONFIG:   w_rd_byte = r_config;
            REG_ID:       w_rd_byte = DEVICE_ID;
            default:      w_rd_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_tx      <= '0;
            r_ptr     <= '0;
            r_config  <= '0;
            r_snap    <= '0;
            r_sda_oe  <= 1'b0;
            r_busy    <= 1'b0;
            r_nack    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_tx      <= w_tx_nxt;
            r_ptr     <= w_ptr_nxt;
            r_config  <= w_config_nxt;
            r_snap    <= w_snap_nxt;
            r_sda_oe  <= w_sda_oe_nxt;
            r_busy    <= w_busy_nxt;
            r_nack    <= w_nack_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_tx_nxt      = r_tx;
        w_ptr_nxt     = r_ptr;
        w_config_nxt  = r_config;
        w_snap_nxt    = r_snap;
        w_sda_oe_nxt  = r_sda_oe;
        w_busy_nxt    = r_busy;
        w_nack_nxt    = r_nack;

        if (w_start) begin
            w_state_nxt   = ST_ADDR;
            w_bit_cnt_nxt = '0;
            w_sda_oe_nxt  = 1'b0;
            w_busy_nxt    = 1'b0;
        end else if (w_stop) begin
            w_state_nxt   = ST_IDLE;
            w_bit_cnt_nxt = '0;
            w_sda_oe_nxt  = 1'b0;
            w_busy_nxt    = 1'b0;
        end else begin
            case (r_state)
                ST_ADDR, ST_PTR, ST_WR_DATA: begin
                    if (w_scl_rise && (r_bit_cnt < 4'd8)) begin
                        w_shift_nxt   = w_byte;
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                        // Last bit of a byte commits it; aborted bytes never reach here.
                        if (r_bit_cnt == 4'd7) begin
                            if (r_state == ST_PTR) begin
                                w_ptr_nxt = w_byte;
                            end else if (r_state == ST_WR_DATA) begin
                                if (r_ptr == REG_CONFIG) begin
                                    w_config_nxt = w_byte;
                                end
                                w_ptr_nxt = r_ptr + 8'd1;
                            end
                        end
                    end else if (w_scl_fall && (r_bit_cnt == 4'd8)) begin
                        w_bit_cnt_nxt = '0;
                        if (r_state == ST_ADDR) begin
                            if (r_shift[7:1] == DEV_ADDR) begin
                                w_state_nxt  = ST_ADDR_ACK;
                                w_sda_oe_nxt = 1'b1;
                                w_busy_nxt   = 1'b1;
                                if (r_shift[0]) begin
                                    w_snap_nxt = temp_in;
                                end
                            end else begin
                                w_state_nxt = ST_WAIT_STOP;
                            end
                        end else begin
                            w_state_nxt  = (r_state == ST_PTR) ? ST_PTR_ACK : ST_WR_ACK;
                            w_sda_oe_nxt = 1'b1;
                        end
                    end
                end

                ST_ADDR_ACK, ST_PTR_ACK, ST_WR_ACK: begin
                    if (w_scl_fall) begin
                        w_bit_cnt_nxt = '0;
                        w_sda_oe_nxt  = 1'b0;
                        if (r_state == ST_ADDR_ACK && r_shift[0]) begin
                            w_state_nxt  = ST_RD_DATA;
                            w_tx_nxt     = w_rd_byte;
                            w_sda_oe_nxt = ~w_rd_byte[7];
                        end else if (r_state == ST_ADDR_ACK) begin
                            w_state_nxt = ST_PTR;
                        end else begin
                            w_state_nxt = ST_WR_DATA;
                        end
                    end
                end

                ST_RD_DATA: begin
                    if (w_scl_rise && (r_bit_cnt < 4'd8)) begin
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    end else if (w_scl_fall) begin
                        if (r_bit_cnt == 4'd8) begin
                            w_state_nxt   = ST_RD_ACK;
                            w_bit_cnt_nxt = '0;
                            w_sda_oe_nxt  = 1'b0;
                            w_ptr_nxt     = r_ptr + 8'd1;
                        end else begin
                            // r_tx[7] is already on the bus; shift the next bit up.
                            w_sda_oe_nxt = ~r_tx[6];
                            w_tx_nxt     = {r_tx[6:0], 1'b0};
                        end
                    end
                end

                ST_RD_ACK: begin
                    if (w_scl_rise) begin
                        w_nack_nxt = w_sda;
                    end else if (w_scl_fall) begin
                        w_bit_cnt_nxt = '0;
                        if (r_nack) begin
                            w_state_nxt  = ST_WAIT_STOP;
                            w_sda_oe_nxt = 1'b0;
                        end else begin
                            w_state_nxt  = ST_RD_DATA;
                            w_tx_nxt     = w_rd_byte;
                            w_sda_oe_nxt = ~w_rd_byte[7];
                        end
                    end
                end

                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end
    end

    assign sda_oe     = r_sda_oe;
    assign config_out = r_config;
    assign busy       = r_busy;
    assign state_dbg  = r_state;
    assign ack_dbg    = r_sda_oe & is_ack_state(r_state);

endmodule
`default_nettype wire

// File: tb/tb_i2c_target_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_target_responder
// Purpose  : Bit-banged I2C controller with a transaction-level register model.
// Revision : 1.0  initial release
// ============================================================================
module tb_i2c_target_responder;

    localparam int         Q   = 8;
    localparam logic [6:0] DEV = 7'h48;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        scl_ctrl = 1'b1;
    logic        sda_ctrl = 1'b1;
    logic        sda_bus;
    logic        sda_oe;
    logic [15:0] temp_in = 16'h0000;
    logic [7:0]  config_out;
    logic        busy;
    logic [7:0]  state_dbg;
    logic        ack_dbg;

    assign sda_bus = sda_ctrl & ~sda_oe;

    i2c_target_responder dut (
        .clk        (clk),
        .reset      (reset),
        .scl_in     (scl_ctrl),
        .sda_in     (sda_bus),
        .sda_oe     (sda_oe),
        .temp_in    (temp_in),
        .config_out (config_out),
        .busy       (busy),
        .state_dbg  (state_dbg),
        .ack_dbg    (ack_dbg)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int c_tests = 0;
    int c_fail  = 0;

    // Model of the register file and of what the bus pins must show.
    logic [7:0]  m_ptr = 8'h00;
    logic [7:0]  m_cfg = 8'h00;
    logic [15:0] m_snap = 16'h0000;
    logic        exp_oe = 1'b0;
    logic        exp_ack = 1'b0;
    logic        exp_busy = 1'b0;
    logic        chk_en = 1'b0;

    function automatic logic [7:0] m_reg(input logic [7:0] a);
        case (a)
            8'h00:   return m_snap[15:8];
            8'h01:   return m_snap[7:0];
            8'h03:   return m_cfg;
            8'h0B:   return 8'hCB;
            default: return 8'h00;
        endcase
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            c_tests++;
            if (sda_oe !== exp_oe || ack_dbg !== exp_ack || busy !== exp_busy || config_out !== m_cfg) begin
                c_fail++;
                $display("FAIL bus_cycle t=%0t: got oe=%b ack=%b busy=%b cfg=%h, expected oe=%b ack=%b busy=%b cfg=%h",
                         $time, sda_oe, ack_dbg, busy, config_out, exp_oe, exp_ack, exp_busy, m_cfg);
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic bus_bit(input logic drv, input logic eoe, input logic eack, output logic rd);
        tick(Q);
        sda_ctrl = drv;
        tick(Q);
        scl_ctrl = 1'b1;
        tick(4);
        exp_oe  = eoe;
        exp_ack = eack;
        chk_en  = 1'b1;
        tick(2*Q-6);
        rd     = sda_bus;
        chk_en = 1'b0;
        tick(2);
        scl_ctrl = 1'b0;
    endtask

    task automatic start_cond();
        if (scl_ctrl == 1'b0) begin
            sda_ctrl = 1'b1;
            tick(Q);
            scl_ctrl = 1'b1;
            tick(Q);
        end
        sda_ctrl = 1'b0;
        exp_busy = 1'b0; exp_oe = 1'b0; exp_ack = 1'b0;
        tick(Q);
        scl_ctrl = 1'b0;
    endtask

    task automatic stop_cond();
        sda_ctrl = 1'b0;
        tick(Q);
        scl_ctrl = 1'b1;
        tick(Q);
        sda_ctrl = 1'b1;
        exp_busy = 1'b0; exp_oe = 1'b0; exp_ack = 1'b0;
        tick(Q);
    endtask

    task automatic idle_check(input int n);
        exp_oe = 1'b0; exp_ack = 1'b0; exp_busy = 1'b0;
        chk_en = 1'b1;
        tick(n);
        chk_en = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ack_exp, input logic is_addr, input logic cfg_wr);
        logic rd;
        for (int i = 7; i >= 0; i--) begin
            if (i == 0 && cfg_wr) m_cfg = b;
            bus_bit(b[i], 1'b0, 1'b0, rd);
        end
        if (is_addr) begin
            exp_busy = ack_exp;
            if (ack_exp && b[0]) m_snap = temp_in;
        end
        bus_bit(1'b1, ack_exp, ack_exp, rd);
        check(is_addr ? "addr_ack" : "data_ack", {15'd0, ~rd}, {15'd0, ack_exp});
    endtask

    task automatic recv_byte(input logic ack_it, input logic rand_temp, output logic [7:0] b);
        logic [7:0] e;
        logic       rd;
        e = m_reg(m_ptr);
        if (rand_temp) temp_in = 16'($urandom);
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, ~e[i], 1'b0, rd);
            b[i] = rd;
        end
        m_ptr = m_ptr + 8'd1;
        check("read_byte", {8'd0, b}, {8'd0, e});
        bus_bit(ack_it ? 1'b0 : 1'b1, 1'b0, 1'b0, rd);
    endtask

    task automatic wr_txn(input logic [6:0] a, input logic [7:0] ptr, input int nd,
                          input logic [7:0] d0, input logic do_stop);
        logic [7:0] d;
        start_cond();
        send_byte({a, 1'b0}, a == DEV, 1'b1, 1'b0);
        if (a == DEV) begin
            send_byte(ptr, 1'b1, 1'b0, 1'b0);
            m_ptr = ptr;
            for (int k = 0; k < nd; k++) begin
                d = (k == 0) ? d0 : 8'($urandom);
                send_byte(d, 1'b1, 1'b0, m_ptr == 8'h03);
                m_ptr = m_ptr + 8'd1;
            end
        end
        if (do_stop) stop_cond();
    endtask

    task automatic rd_txn(input int nb);
        logic [7:0] b;
        start_cond();
        send_byte({DEV, 1'b1}, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < nb; k++) recv_byte(k != nb - 1, 1'b1, b);
        stop_cond();
    endtask

    function automatic logic [7:0] pick_ptr();
        case ($urandom_range(0, 7))
            0: return 8'h00;
            1: return 8'h01;
            2: return 8'h02;
            3: return 8'h03;
            4: return 8'h03;
            5: return 8'h0B;
            6: return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        logic [7:0] b;
        logic       rd;
        logic [7:0] p;

        // Reset state
        tick(5);
        #1;
        check("reset_sda_oe", {15'd0, sda_oe}, 16'd0);
        check("reset_busy", {15'd0, busy}, 16'd0);
        check("reset_ack_dbg", {15'd0, ack_dbg}, 16'd0);
        check("reset_config", {8'd0, config_out}, 16'h0000);
        check("reset_state", {8'd0, state_dbg}, 16'h0000);
        reset = 1'b0;
        idle_check(20);

        // Config write
        wr_txn(DEV, 8'h03, 1, 8'h5A, 1'b1);
        check("config_5a", {8'd0, config_out}, 16'h005A);
        idle_check(8);

        // Temperature read through repeated START
        temp_in = 16'h0C80;
        wr_txn(DEV, 8'h00, 0, 8'h00, 1'b0);
        start_cond();
        send_byte({DEV, 1'b1}, 1'b1, 1'b1, 1'b0);
        recv_byte(1'b1, 1'b0, b);
        check("temp_msb", {8'd0, b}, 16'h000C);
        recv_byte(1'b0, 1'b0, b);
        check("temp_lsb", {8'd0, b}, 16'h0080);
        stop_cond();
        idle_check(8);

        // Device ID
        wr_txn(DEV, 8'h0B, 0, 8'h00, 1'b0);
        start_cond();
        send_byte({DEV, 1'b1}, 1'b1, 1'b1, 1'b0);
        recv_byte(1'b0, 1'b0, b);
        check("device_id", {8'd0, b}, 16'h00CB);
        stop_cond();
        idle_check(8);

        // Foreign address is ignored
        start_cond();
        send_byte(8'h92, 1'b0, 1'b1, 1'b0);
        send_byte(8'hA5, 1'b0, 1'b0, 1'b0);
        check("mismatch_state", {8'd0, state_dbg}, 16'd9);
        check("mismatch_busy", {15'd0, busy}, 16'd0);
        stop_cond();
        idle_check(8);

        // Pointer wrap
        temp_in = 16'h1A2B;
        wr_txn(DEV, 8'hFF, 0, 8'h00, 1'b1);
        start_cond();
        send_byte({DEV, 1'b1}, 1'b1, 1'b1, 1'b0);
        recv_byte(1'b1, 1'b0, b);
        check("wrap_first", {8'd0, b}, 16'h0000);
        recv_byte(1'b0, 1'b0, b);
        check("wrap_second", {8'd0, b}, 16'h001A);
        stop_cond();
        idle_check(8);

        // STOP inside a write byte leaves config and pointer alone
        wr_txn(DEV, 8'h03, 0, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) bus_bit(1'b1, 1'b0, 1'b0, rd);
        stop_cond();
        check("abort_config", {8'd0, config_out}, 16'h005A);
        start_cond();
        send_byte({DEV, 1'b1}, 1'b1, 1'b1, 1'b0);
        recv_byte(1'b0, 1'b0, b);
        check("abort_ptr_read", {8'd0, b}, 16'h005A);
        stop_cond();
        idle_check(8);

        // Reset during the fifth read bit of an all-zero register
        wr_txn(DEV, 8'h02, 0, 8'h00, 1'b0);
        start_cond();
        send_byte({DEV, 1'b1}, 1'b1, 1'b1, 1'b0);
        for (int i = 7; i >= 4; i--) bus_bit(1'b1, 1'b1, 1'b0, rd);
        tick(Q);
        sda_ctrl = 1'b1;
        tick(Q);
        scl_ctrl = 1'b1;
        tick(4);
        #1;
        check("oe_before_reset", {15'd0, sda_oe}, 16'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("oe_after_reset", {15'd0, sda_oe}, 16'd0);
        check("busy_after_reset", {15'd0, busy}, 16'd0);
        check("config_after_reset", {8'd0, config_out}, 16'h0000);
        reset = 1'b0;
        m_cfg = 8'h00; m_ptr = 8'h00; m_snap = 16'h0000;
        exp_busy = 1'b0;
        tick(Q);
        scl_ctrl = 1'b0;
        for (int i = 0; i < 3; i++) bus_bit(1'b1, 1'b0, 1'b0, rd);
        stop_cond();
        idle_check(8);

        // Randomized traffic against the model
        for (int t = 0; t < 16; t++) begin
            temp_in = 16'($urandom);
            p = pick_ptr();
            case ($urandom_range(0, 3))
                0: wr_txn(($urandom_range(0, 5) == 0) ? 7'($urandom) : DEV, p,
                          int'($urandom_range(0, 3)), 8'($urandom), 1'b1);
                1: rd_txn(int'($urandom_range(1, 3)));
                2: begin
                    wr_txn(DEV, p, 0, 8'h00, 1'b0);
                    rd_txn(int'($urandom_range(1, 3)));
                end
                default: begin
                    wr_txn(DEV, p, int'($urandom_range(0, 1)), 8'($urandom), 1'b0);
                    for (int i = 0; i < int'($urandom_range(1, 6)); i++)
                        bus_bit(1'($urandom), 1'b0, 1'b0, rd);
                    if ($urandom_range(0, 1) == 1) start_cond();
                    stop_cond();
                end
            endcase
            idle_check(8);
        end

        n_tests += c_tests;
        n_fail  += c_fail;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
